// File: rtl/header_pkg.sv
// Shared byte constants and state encodings for the header transmitter and receiver.
package header_pkg;

  localparam logic [7:0] HDR_BYTE_A     = 8'h55;
  localparam logic [7:0] HDR_BYTE_B     = 8'hD5;
  localparam logic [7:0] IDLE_BYTE_DFLT = 8'h00;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HDR     = 3'd1;
  localparam logic [2:0] ST_PAYLOAD = 3'd2;
  localparam logic [2:0] ST_CSUM    = 3'd3;
  localparam logic [2:0] ST_GAP     = 3'd4;

  // Counter width covering the longer of header and gap, never below one bit.
  function automatic int cnt_width(input int hdr_len, input int gap_len);
    int m;
    m = 2;
    if (hdr_len > m) m = hdr_len;
    if (gap_len > m) m = gap_len;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/header_csum_acc.sv
// XOR accumulator over accepted payload bytes; used when HEADER_TX_CSUM_EN is defined.
module header_csum_acc (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] din,
  output logic [7:0] acc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (enable) begin
      acc <= acc ^ din;
    end
  end

endmodule

// File: rtl/header_tx.sv
// Frames a payload byte stream with an alternating 0x55/0xD5 header and an idle gap.
// Define HEADER_TX_CSUM_EN to append an XOR checksum byte after the payload.
module header_tx
  import header_pkg::*;
#(
  parameter int         HDR_LEN   = 12,
  parameter int         GAP_LEN   = 4,
  parameter logic [7:0] IDLE_BYTE = IDLE_BYTE_DFLT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] dout,
  output logic       dout_vld,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  localparam int             CW       = cnt_width(HDR_LEN, GAP_LEN);
  localparam logic [CW-1:0]  HDR_LAST = CW'(HDR_LEN - 1);
  localparam logic [CW-1:0]  GAP_LAST = CW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
  localparam logic [2:0]     ST_AFTER = (GAP_LEN > 0) ? ST_GAP : ST_IDLE;
`ifdef HEADER_TX_CSUM_EN
  localparam bit             CSUM_EN  = 1'b1;
`else
  localparam bit             CSUM_EN  = 1'b0;
`endif
  localparam logic [2:0]     ST_END   = CSUM_EN ? ST_CSUM : ST_AFTER;

  logic [2:0]    state;
  logic [CW-1:0] hdr_cnt;
  logic [CW-1:0] gap_cnt;
  logic          slot;
  logic          accept;

  // The last header cycle already accepts the first payload byte so no bubble appears.
  assign slot    = (state == ST_PAYLOAD) || ((state == ST_HDR) && (hdr_cnt == HDR_LAST));
  assign s_ready = slot;
  assign accept  = slot && s_valid;

`ifdef HEADER_TX_CSUM_EN
  logic [7:0] csum;

  header_csum_acc u_csum (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  ((state == ST_IDLE) && s_valid),
    .enable (accept),
    .din    (s_data),
    .acc    (csum)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      hdr_cnt  <= '0;
      gap_cnt  <= '0;
      dout     <= IDLE_BYTE;
      dout_vld <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      dout     <= IDLE_BYTE;
      dout_vld <= 1'b0;
      done     <= 1'b0;
      underrun <= 1'b0;
      busy     <= 1'b1;
      case (state)
        ST_IDLE: begin
          busy <= s_valid;
          if (s_valid) begin
            state    <= ST_HDR;
            hdr_cnt  <= '0;
            dout     <= HDR_BYTE_A;
            dout_vld <= 1'b1;
          end
        end
        ST_HDR: begin
          if (hdr_cnt != HDR_LAST) begin
            hdr_cnt  <= hdr_cnt + CW'(1);
            dout     <= hdr_cnt[0] ? HDR_BYTE_A : HDR_BYTE_B;
            dout_vld <= 1'b1;
          end else begin
            state <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
        end
`ifdef HEADER_TX_CSUM_EN
        ST_CSUM: begin
          dout     <= csum;
          dout_vld <= 1'b1;
          done     <= 1'b1;
          state    <= ST_AFTER;
          gap_cnt  <= '0;
        end
`endif
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Payload slot: forward the byte, or flag a bubble while holding the frame open.
      if (slot) begin
        if (s_valid) begin
          dout     <= s_data;
          dout_vld <= 1'b1;
          if (s_last) begin
            state   <= ST_END;
            gap_cnt <= '0;
            done    <= !CSUM_EN;
          end
        end else begin
          underrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_header_tx.sv
// Randomized bench for header_tx against a frame-level model, plus literal spot checks.
module tb_header_tx;
  import header_pkg::*;

  localparam int HL = 12;
  localparam int NT = 8192;
`ifdef HEADER_TX_CSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] s_data [2];
  logic       s_valid [2];
  logic       s_last [2];
  logic       s_ready [2];
  logic [7:0] dout [2];
  logic       dout_vld [2];
  logic       busy [2];
  logic       done [2];
  logic       underrun [2];

  header_tx #(.HDR_LEN(HL), .GAP_LEN(4), .IDLE_BYTE(8'h00)) dut_a (
    .clk(clk), .rst_n(rst_n), .s_data(s_data[0]), .s_valid(s_valid[0]), .s_last(s_last[0]),
    .s_ready(s_ready[0]), .dout(dout[0]), .dout_vld(dout_vld[0]), .busy(busy[0]),
    .done(done[0]), .underrun(underrun[0])
  );

  header_tx #(.HDR_LEN(HL), .GAP_LEN(0), .IDLE_BYTE(8'h00)) dut_b (
    .clk(clk), .rst_n(rst_n), .s_data(s_data[1]), .s_valid(s_valid[1]), .s_last(s_last[1]),
    .s_ready(s_ready[1]), .dout(dout[1]), .dout_vld(dout_vld[1]), .busy(busy[1]),
    .done(done[1]), .underrun(underrun[1])
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Frame-level model state per DUT.
  bit         m_act [2];
  int         m_hdr [2];
  bit         m_csum [2];
  int         m_gap [2];
  logic [7:0] m_acc [2];
  logic [7:0] e_dout [2];
  bit         e_vld [2], e_busy [2], e_done [2], e_und [2], e_rdy [2], e_pay [2];

  logic [7:0] sbq [2][$];
  logic [7:0] fb [$];

  logic [7:0] tr_dout [2][NT];
  bit         tr_vld [2][NT], tr_busy [2][NT], tr_done [2][NT], tr_und [2][NT];

  function automatic int gap_len(input int i);
    return (i == 0) ? 4 : 0;
  endfunction

  function automatic int ix(input int n0, input int k);
    return (n0 + k - 1) % NT;
  endfunction

  task automatic check(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d edge %0d: got %0h expected %0h", nm, i, cyc, act, exp);
    end
  endtask

  task automatic model_reset(input int i);
    m_act[i] = 0; m_hdr[i] = 0; m_csum[i] = 0; m_gap[i] = 0; m_acc[i] = 8'h00;
    e_dout[i] = 8'h00; e_vld[i] = 0; e_busy[i] = 0; e_done[i] = 0;
    e_und[i] = 0; e_rdy[i] = 0; e_pay[i] = 0;
  endtask

  task automatic close_frame(input int i);
    m_gap[i] = gap_len(i);
    if (m_gap[i] == 0) m_act[i] = 0;
  endtask

  task automatic model_step(input int i, input bit v, input logic [7:0] d, input bit l);
    e_dout[i] = 8'h00; e_vld[i] = 0; e_done[i] = 0; e_und[i] = 0; e_pay[i] = 0; e_busy[i] = 1;
    if (!m_act[i]) begin
      if (v) begin
        m_act[i] = 1; m_hdr[i] = 1; m_acc[i] = 8'h00;
        e_dout[i] = 8'h55; e_vld[i] = 1;
      end else begin
        e_busy[i] = 0;
      end
    end else if (m_hdr[i] < HL) begin
      e_dout[i] = (m_hdr[i] % 2 == 0) ? 8'h55 : 8'hD5;
      e_vld[i] = 1;
      m_hdr[i]++;
    end else if (m_csum[i]) begin
      e_dout[i] = m_acc[i]; e_vld[i] = 1; e_done[i] = 1; m_csum[i] = 0;
      close_frame(i);
    end else if (m_gap[i] > 0) begin
      m_gap[i]--;
      if (m_gap[i] == 0) m_act[i] = 0;
    end else if (v) begin
      e_dout[i] = d; e_vld[i] = 1; e_pay[i] = 1; m_acc[i] = m_acc[i] ^ d;
      if (l) begin
        if (CS != 0) m_csum[i] = 1;
        else begin
          e_done[i] = 1;
          close_frame(i);
        end
      end
    end else begin
      e_und[i] = 1;
    end
    e_rdy[i] = m_act[i] && (m_hdr[i] == HL) && !m_csum[i] && (m_gap[i] == 0);
  endtask

  // Model advances on the sampled inputs; DUT outputs are compared just after the edge.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) model_reset(i);
      else model_step(i, s_valid[i], s_data[i], s_last[i]);
    end
    cyc++;
    #1;
    for (int i = 0; i < 2; i++) begin
      tr_dout[i][cyc % NT] = dout[i];
      tr_vld[i][cyc % NT]  = dout_vld[i];
      tr_busy[i][cyc % NT] = busy[i];
      tr_done[i][cyc % NT] = done[i];
      tr_und[i][cyc % NT]  = underrun[i];
      check("outputs", i,
            32'({dout[i], dout_vld[i], busy[i], done[i], underrun[i], s_ready[i]}),
            32'({e_dout[i], e_vld[i], e_busy[i], e_done[i], e_und[i], e_rdy[i]}));
      if (e_pay[i]) begin
        if (sbq[i].size() > 0) check("scoreboard", i, 32'(dout[i]), 32'(sbq[i].pop_front()));
        else check("scoreboard", i, 32'(dout[i]), 32'hFFFF_FFFF);
      end
    end
  end

  task automatic send_frame(input int i, input int bub, input int hold_k, input int hold_n,
                            input bit keep, output int n0);
    int k;
    int guard;
    int h;
    bit started;
    k = 0; guard = 0; h = 0; started = 0; n0 = 0;
    while (k < fb.size() && guard < 400) begin
      @(negedge clk);
      guard++;
      if (k == hold_k && h < hold_n) begin
        h++;
        s_valid[i] = 1'b0; s_data[i] = 8'($urandom); s_last[i] = 1'($urandom);
      end else if (bub > 0 && $urandom_range(0, 99) < bub) begin
        s_valid[i] = 1'b0; s_data[i] = 8'($urandom); s_last[i] = 1'($urandom);
      end else begin
        if (!started) begin
          started = 1;
          n0 = cyc + 1;
        end
        s_valid[i] = 1'b1; s_data[i] = fb[k]; s_last[i] = (k == fb.size() - 1);
        if (s_ready[i]) begin
          sbq[i].push_back(fb[k]);
          k++;
        end
      end
    end
    if (k < fb.size()) check("handshake_timeout", i, 32'(k), 32'(fb.size()));
    if (!keep) begin
      @(negedge clk);
      s_valid[i] = 1'b0;
    end
  endtask

  task automatic rand_frame(input int maxlen);
    int n;
    n = $urandom_range(1, maxlen);
    fb = {};
    for (int j = 0; j < n; j++) fb.push_back(8'($urandom));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int n0;
    int n1;
    for (int i = 0; i < 2; i++) begin
      s_valid[i] = 1'b0; s_data[i] = 8'h00; s_last[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_dout", i, 32'(dout[i]), 32'h00);
      check("rst_vld", i, 32'(dout_vld[i]), 32'h0);
      check("rst_busy", i, 32'(busy[i]), 32'h0);
      check("rst_done", i, 32'(done[i]), 32'h0);
      check("rst_underrun", i, 32'(underrun[i]), 32'h0);
      check("rst_ready", i, 32'(s_ready[i]), 32'h0);
    end
    rst_n = 1'b1;

    // Single frame 11 22 33.
    fb = '{8'h11, 8'h22, 8'h33};
    send_frame(0, 0, -1, 0, 0, n0);
    repeat (25) @(negedge clk);
    check("busy_before", 0, 32'(tr_busy[0][ix(n0, 0)]), 32'h0);
    for (int k = 1; k <= 12; k++) begin
      check("hdr_byte", 0, 32'(tr_dout[0][ix(n0, k)]), (k % 2 == 1) ? 32'h55 : 32'hD5);
      check("hdr_vld", 0, 32'(tr_vld[0][ix(n0, k)]), 32'h1);
    end
    check("pay_11", 0, 32'(tr_dout[0][ix(n0, 13)]), 32'h11);
    check("pay_22", 0, 32'(tr_dout[0][ix(n0, 14)]), 32'h22);
    check("pay_33", 0, 32'(tr_dout[0][ix(n0, 15)]), 32'h33);
    check("done_early", 0, 32'(tr_done[0][ix(n0, 14)]), 32'h0);
    if (CS != 0) check("csum_byte", 0, 32'(tr_dout[0][ix(n0, 16)]), 32'h00);
    check("done", 0, 32'(tr_done[0][ix(n0, 15 + CS)]), 32'h1);
    for (int k = 16 + CS; k <= 19 + CS; k++) begin
      check("gap_vld", 0, 32'(tr_vld[0][ix(n0, k)]), 32'h0);
      check("gap_busy", 0, 32'(tr_busy[0][ix(n0, k)]), 32'h1);
    end
    check("busy_fall", 0, 32'(tr_busy[0][ix(n0, 20 + CS)]), 32'h0);

    // Two-cycle bubble before 0x33.
    fb = '{8'h11, 8'h22, 8'h33};
    send_frame(0, 0, 2, 2, 0, n0);
    repeat (25) @(negedge clk);
    check("ur_pay_11", 0, 32'(tr_dout[0][ix(n0, 13)]), 32'h11);
    check("ur_pay_22", 0, 32'(tr_dout[0][ix(n0, 14)]), 32'h22);
    check("ur_none", 0, 32'(tr_und[0][ix(n0, 14)]), 32'h0);
    for (int k = 15; k <= 16; k++) begin
      check("ur_pulse", 0, 32'(tr_und[0][ix(n0, k)]), 32'h1);
      check("ur_vld", 0, 32'(tr_vld[0][ix(n0, k)]), 32'h0);
      check("ur_dout", 0, 32'(tr_dout[0][ix(n0, k)]), 32'h00);
    end
    check("ur_pay_33", 0, 32'(tr_dout[0][ix(n0, 17)]), 32'h33);
    check("ur_done", 0, 32'(tr_done[0][ix(n0, 17 + CS)]), 32'h1);

`ifdef HEADER_TX_CSUM_EN
    fb = '{8'hA5, 8'h0F, 8'hF0};
    send_frame(0, 0, -1, 0, 0, n0);
    repeat (25) @(negedge clk);
    check("cs_last_pay", 0, 32'(tr_dout[0][ix(n0, 15)]), 32'hF0);
    check("cs_no_done", 0, 32'(tr_done[0][ix(n0, 15)]), 32'h0);
    check("cs_byte", 0, 32'(tr_dout[0][ix(n0, 16)]), 32'h5A);
    check("cs_vld", 0, 32'(tr_vld[0][ix(n0, 16)]), 32'h1);
    check("cs_done", 0, 32'(tr_done[0][ix(n0, 16)]), 32'h1);
`endif

    // Asynchronous reset in the middle of the header.
    @(negedge clk);
    s_valid[0] = 1'b1; s_data[0] = 8'h77; s_last[0] = 1'b0;
    n0 = cyc + 1;
    wait (cyc == n0 + 5);
    #3;
    check("pre_rst_dout", 0, 32'(dout[0]), 32'hD5);
    rst_n = 1'b0;
    #1;
    check("arst_dout", 0, 32'(dout[0]), 32'h00);
    check("arst_vld", 0, 32'(dout_vld[0]), 32'h0);
    check("arst_busy", 0, 32'(busy[0]), 32'h0);
    check("arst_done", 0, 32'(done[0]), 32'h0);
    check("arst_ready", 0, 32'(s_ready[0]), 32'h0);
    s_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fb = '{8'h44};
    send_frame(0, 0, -1, 0, 0, n0);
    repeat (20) @(negedge clk);
    check("post_rst_first", 0, 32'(tr_dout[0][ix(n0, 1)]), 32'h55);
    check("post_rst_pay", 0, 32'(tr_dout[0][ix(n0, 13)]), 32'h44);

    // Back-to-back frames with no gap and s_valid held high.
    fb = '{8'h3C};
    send_frame(1, 0, -1, 0, 1, n0);
    fb = '{8'hC3, 8'h5A};
    send_frame(1, 0, -1, 0, 1, n1);
    for (int f = 0; f < 30; f++) begin
      rand_frame(3);
      send_frame(1, 0, -1, 0, (f != 29), n1);
    end
    repeat (20) @(negedge clk);
    check("b2b_byte", 1, 32'(tr_dout[1][ix(n0, 13)]), 32'h3C);
    check("b2b_done", 1, 32'(tr_done[1][ix(n0, 13 + CS)]), 32'h1);
    check("b2b_busy", 1, 32'(tr_busy[1][ix(n0, 13 + CS)]), 32'h1);
    check("b2b_next_hdr", 1, 32'(tr_dout[1][ix(n0, 14 + CS)]), 32'h55);
    check("b2b_next_vld", 1, 32'(tr_vld[1][ix(n0, 14 + CS)]), 32'h1);
    check("b2b_f2_b0", 1, 32'(tr_dout[1][ix(n0, 26 + CS)]), 32'hC3);
    check("b2b_f2_b1", 1, 32'(tr_dout[1][ix(n0, 27 + CS)]), 32'h5A);

    // Random frames with bubbles and idle spacing.
    for (int f = 0; f < 30; f++) begin
      rand_frame(6);
      send_frame(0, 25, $urandom_range(0, 5), $urandom_range(0, 2), 0, n0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    repeat (30) @(negedge clk);
    for (int i = 0; i < 2; i++) check("sb_drain", i, 32'(sbq[i].size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
